// File: rtl/stack_ctrl_fsm.sv
// stack_ctrl_fsm: multicycle control FSM for the stack-machine CPU.
// Decodes a 4-bit opcode space (plus optional high bits, which are illegal),
// sequences the datapath strobes, waits on a memory-ready handshake, tracks
// stack occupancy and traps on underflow, overflow and illegal opcodes.
module stack_ctrl_fsm #(
    parameter int OPW   = 4,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCJZ,
    output logic           AdrSrc,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           DataSelect,
    output logic           push,
    output logic           pop,
    output logic           tos,
    output logic           AWrite,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           PCSrc,
    output logic [2:0]     ALUControl,
    output logic [SPW-1:0] sp_count,
    output logic           retire,
    output logic           halted,
    output logic           trap,
    output logic [1:0]     trap_code
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_BIN_POP, S_BIN_EXEC, S_BIN_PUSH, S_UN_EXEC,
        S_UN_PUSH, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_JMP, S_JZ, S_DUP_LD,
        S_DUP_PUSH, S_HALT, S_TRAP
    } state_t;

    localparam logic [1:0] TC_UNDER   = 2'b01;
    localparam logic [1:0] TC_OVER    = 2'b10;
    localparam logic [1:0] TC_ILLEGAL = 2'b11;

    state_t         r_state;
    state_t         w_next;
    logic [SPW-1:0] r_sp;
    logic [1:0]     r_trap_code;

    logic [3:0] w_op_lo;
    logic       w_high_set;
    logic       w_is_bin, w_is_not, w_is_push, w_is_pop;
    logic       w_is_jmp, w_is_jz, w_is_dup, w_is_halt, w_illegal;
    logic       w_underflow, w_overflow;
    logic [1:0] w_fault_code;
    logic       w_fault;

    assign w_op_lo = opcode[3:0];

    // Any bit above the 4-bit opcode field makes the instruction illegal.
    generate
        if (OPW > 4) begin : g_wide_op
            assign w_high_set = |opcode[OPW-1:4];
        end else begin : g_narrow_op
            assign w_high_set = 1'b0;
        end
    endgenerate

    // Classify the opcode; codes 11..14 fall through as illegal.
    always_comb begin
        w_is_bin  = 1'b0;
        w_is_not  = 1'b0;
        w_is_push = 1'b0;
        w_is_pop  = 1'b0;
        w_is_jmp  = 1'b0;
        w_is_jz   = 1'b0;
        w_is_dup  = 1'b0;
        w_is_halt = 1'b0;
        if (!w_high_set) begin
            case (w_op_lo)
                4'd0, 4'd1, 4'd2, 4'd8, 4'd9: w_is_bin  = 1'b1;
                4'd3:                         w_is_not  = 1'b1;
                4'd4:                         w_is_push = 1'b1;
                4'd5:                         w_is_pop  = 1'b1;
                4'd6:                         w_is_jmp  = 1'b1;
                4'd7:                         w_is_jz   = 1'b1;
                4'd10:                        w_is_dup  = 1'b1;
                4'd15:                        w_is_halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_illegal = !(w_is_bin | w_is_not | w_is_push | w_is_pop |
                         w_is_jmp | w_is_jz | w_is_dup | w_is_halt);

    // Binary ops need two operands, the other consumers need one.
    assign w_underflow = (w_is_bin && (r_sp < SPW'(2))) ||
                         ((w_is_not || w_is_pop || w_is_jz || w_is_dup) &&
                          (r_sp == '0));
    assign w_overflow  = (w_is_push || w_is_dup) && (r_sp == SPW'(DEPTH));

    // Fault priority: illegal beats underflow beats overflow.
    always_comb begin
        w_fault_code = 2'b00;
        if (w_illegal)        w_fault_code = TC_ILLEGAL;
        else if (w_underflow) w_fault_code = TC_UNDER;
        else if (w_overflow)  w_fault_code = TC_OVER;
    end

    assign w_fault = (w_fault_code != 2'b00);

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state logic: memory states stall on mem_ready, HALT/TRAP absorb.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_fault)        w_next = S_TRAP;
                else if (w_is_bin)  w_next = S_BIN_POP;
                else if (w_is_not)  w_next = S_UN_EXEC;
                else if (w_is_push) w_next = S_MEM_RD;
                else if (w_is_pop)  w_next = S_MEM_WR;
                else if (w_is_jmp)  w_next = S_JMP;
                else if (w_is_jz)   w_next = S_JZ;
                else if (w_is_dup)  w_next = S_DUP_LD;
                else                w_next = S_HALT;
            end
            S_BIN_POP:  w_next = S_BIN_EXEC;
            S_BIN_EXEC: w_next = S_BIN_PUSH;
            S_BIN_PUSH: w_next = S_FETCH;
            S_UN_EXEC:  w_next = S_UN_PUSH;
            S_UN_PUSH:  w_next = S_FETCH;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_JMP:      w_next = S_FETCH;
            S_JZ:       w_next = S_FETCH;
            S_DUP_LD:   w_next = S_DUP_PUSH;
            S_DUP_PUSH: w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // Datapath strobes, decoded from state, opcode and mem_ready.
    always_comb begin
        PCWrite    = 1'b0;
        PCJZ       = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        DataSelect = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        tos        = 1'b0;
        AWrite     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        PCSrc      = 1'b0;
        ALUControl = 3'b000;
        retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                // A faulting instruction must leave the stack untouched.
                if (!w_fault) begin
                    pop = w_is_bin | w_is_not | w_is_pop;
                    tos = w_is_jz | w_is_dup;
                end
            end
            S_BIN_POP: begin
                pop    = 1'b1;
                AWrite = 1'b1;
            end
            S_BIN_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 1'b1;
                case (w_op_lo)
                    4'd1:    ALUControl = 3'b001;
                    4'd2:    ALUControl = 3'b010;
                    4'd8:    ALUControl = 3'b100;
                    4'd9:    ALUControl = 3'b101;
                    default: ALUControl = 3'b000;
                endcase
            end
            S_BIN_PUSH, S_UN_PUSH: begin
                push   = 1'b1;
                retire = 1'b1;
            end
            S_UN_EXEC: begin
                ALUSrcB    = 1'b1;
                ALUControl = 3'b011;
            end
            S_MEM_RD: AdrSrc = 1'b1;
            S_MEM_WB: begin
                DataSelect = 1'b1;
                push       = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_JMP: begin
                PCSrc   = 1'b1;
                PCWrite = 1'b1;
                retire  = 1'b1;
            end
            S_JZ: begin
                PCSrc  = 1'b1;
                PCJZ   = 1'b1;
                retire = 1'b1;
            end
            S_DUP_LD: AWrite = 1'b1;
            S_DUP_PUSH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                push       = 1'b1;
                retire     = 1'b1;
            end
            default: ;
        endcase
    end

    // Occupancy counter; the DECODE fault checks keep it within 0..DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_sp <= '0;
        else if (push) r_sp <= r_sp + SPW'(1);
        else if (pop)  r_sp <= r_sp - SPW'(1);
    end

    // Capture the fault cause as the FSM enters TRAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_trap_code <= 2'b00;
        else if (r_state == S_DECODE && w_fault) r_trap_code <= w_fault_code;
    end

    assign sp_count  = r_sp;
    assign trap_code = r_trap_code;
    assign halted    = (r_state == S_HALT);
    assign trap      = (r_state == S_TRAP);

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Testbench for stack_ctrl_fsm: reset checks, cycle-exact strobe traces,
// an instruction-level vector table, trap/halt corner cases and randomized
// instruction streams checked against an instruction-level model.
module tb_stack_ctrl_fsm;

    localparam int OPW   = 4;
    localparam int DEPTH = 16;
    localparam int SPW   = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                           OP_NOT = 4'd3, OP_PUSH = 4'd4, OP_POP = 4'd5,
                           OP_JMP = 4'd6, OP_JZ = 4'd7, OP_OR = 4'd8,
                           OP_XOR = 4'd9, OP_DUP = 4'd10, OP_HALT = 4'd15;

    // Strobe vector bit masks: {PCWrite..PCSrc, ALUControl, retire}
    localparam logic [16:0] M_PCW  = 17'h10000, M_PCJZ = 17'h08000,
                            M_ADR  = 17'h04000, M_MW   = 17'h02000,
                            M_IRW  = 17'h01000, M_DSEL = 17'h00800,
                            M_PUSH = 17'h00400, M_POP  = 17'h00200,
                            M_TOS  = 17'h00100, M_AW   = 17'h00080,
                            M_SA   = 17'h00040, M_SB   = 17'h00020,
                            M_PCS  = 17'h00010, M_RET  = 17'h00001;
    localparam logic [16:0] M_FI = M_PCW | M_IRW;

    // Kind of instruction ending
    localparam int K_RETIRE = 0, K_TRAP = 1, K_HALT = 2, K_TIMEOUT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic PCWrite, PCJZ, AdrSrc, MemWrite, IRWrite, DataSelect, push, pop, tos;
    logic AWrite, ALUSrcA, ALUSrcB, PCSrc, retire, halted, trap;
    logic [2:0]     ALUControl;
    logic [SPW-1:0] sp_count;
    logic [1:0]     trap_code;
    logic [16:0]    w_vec;

    int n_total = 0;
    int n_pass  = 0;

    stack_ctrl_fsm #(.OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCJZ(PCJZ), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .DataSelect(DataSelect), .push(push), .pop(pop),
        .tos(tos), .AWrite(AWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .sp_count(sp_count),
        .retire(retire), .halted(halted), .trap(trap), .trap_code(trap_code)
    );

    always #5 clk = ~clk;

    assign w_vec = {PCWrite, PCJZ, AdrSrc, MemWrite, IRWrite, DataSelect, push,
                    pop, tos, AWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, retire};

    function automatic logic [16:0] alu(input logic [2:0] a);
        return {13'b0, a, 1'b0};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Instruction-level reference: outcome, length, stack effect.
    function automatic void model(input logic [3:0] op, input int s,
                                  input int nf, input int nm,
                                  output int kind, output int len,
                                  output int ns, output int npush,
                                  output int npop, output int code);
        int need;
        bit legal, grows;
        legal = !(op >= 4'd11 && op <= 4'd14);
        need  = (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) ? 2 :
                (op inside {OP_NOT, OP_POP, OP_JZ, OP_DUP}) ? 1 : 0;
        grows = (op == OP_PUSH) || (op == OP_DUP);
        kind = K_RETIRE; ns = s; npush = 0; npop = 0; code = 0;
        len  = nf + 3;
        if (!legal)                  begin kind = K_TRAP; code = 3; end
        else if (s < need)           begin kind = K_TRAP; code = 1; end
        else if (grows && s == DEPTH) begin kind = K_TRAP; code = 2; end
        else if (op == OP_HALT)      kind = K_HALT;
        else begin
            case (op)
                OP_NOT:  begin npop = 1; npush = 1; len = nf + 4; end
                OP_PUSH: begin npush = 1; len = nf + 4 + nm; end
                OP_POP:  begin npop = 1; len = nf + 3 + nm; end
                OP_JMP, OP_JZ: len = nf + 3;
                OP_DUP:  begin npush = 1; len = nf + 4; end
                default: begin npop = 2; npush = 1; len = nf + 5; end
            endcase
            ns = s - npop + npush;
        end
    endfunction

    // Drives one instruction with nf FETCH stalls and nm memory stalls;
    // mem_ready and opcode are randomized wherever they must not matter.
    task automatic run_instr(input logic [3:0] op, input int nf, input int nm,
                             input int kind, input int len, input int sp,
                             input int npush, input int npop, input int code,
                             input string name);
        int k = 0, end_kind = K_TIMEOUT, end_len = 0;
        int pushes = 0, pops = 0, overlap = 0;
        bit done = 0;
        bit is_mem = (op == OP_PUSH) || (op == OP_POP);
        while (!done && k < 60) begin
            if (k < nf) mem_ready = 1'b0;
            else if (k == nf) mem_ready = 1'b1;
            else if (is_mem && k >= nf + 2 && k < nf + 2 + nm) mem_ready = 1'b0;
            else if (is_mem && k == nf + 2 + nm) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            opcode = (k <= nf) ? 4'($urandom) : op;
            @(negedge clk);
            if (push) pushes++;
            if (pop) pops++;
            if (push && pop) overlap++;
            if (retire)      begin end_kind = K_RETIRE; done = 1; end
            else if (trap)   begin end_kind = K_TRAP;   done = 1; end
            else if (halted) begin end_kind = K_HALT;   done = 1; end
            end_len = k + 1;
            @(posedge clk); #1;
            k++;
        end
        chk({name, " end_kind"}, end_kind, kind);
        chk({name, " length"}, end_len, len);
        chk({name, " sp_count"}, sp_count, sp);
        chk({name, " pushes"}, pushes, npush);
        chk({name, " pops"}, pops, npop);
        chk({name, " push_pop_overlap"}, overlap, 0);
        if (kind == K_TRAP) chk({name, " trap_code"}, trap_code, code);
        $display("txn %s op=%0d nf=%0d nm=%0d end=%0d len=%0d sp=%0d",
                 name, op, nf, nm, end_kind, end_len, sp_count);
    endtask

    // Reset asserted away from the clock edge; flags must clear at once.
    task automatic do_reset(input string name);
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #2;
        chk({name, " rst sp_count"}, sp_count, 0);
        chk({name, " rst trap"}, trap, 0);
        chk({name, " rst halted"}, halted, 0);
        chk({name, " rst trap_code"}, trap_code, 0);
        chk({name, " rst strobes"}, w_vec, mem_ready ? M_FI : 17'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Cycle-exact strobe traces for hand-written sequences
    logic [16:0] seq_exp [0:15];
    logic        seq_mr  [0:15];
    int          seq_n = 0;

    task automatic step(input logic mr, input logic [16:0] v);
        seq_mr[seq_n]  = mr;
        seq_exp[seq_n] = v;
        seq_n++;
    endtask

    task automatic run_seq(input logic [3:0] op, input int sp, input string name);
        for (int i = 0; i < seq_n; i++) begin
            mem_ready = seq_mr[i];
            opcode    = op;
            @(negedge clk);
            chk($sformatf("%s cycle%0d strobes", name, i), w_vec, seq_exp[i]);
            @(posedge clk); #1;
        end
        chk({name, " sp_count"}, sp_count, sp);
        $display("txn %s op=%0d cycles=%0d sp=%0d", name, op, seq_n, sp_count);
        seq_n = 0;
    endtask

    typedef struct {
        logic [3:0] op;
        int nf, nm, kind, len, sp, npush, npop, code;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int kind, len, ns, np, npo, code, s, nf, nm, bad;
        logic [3:0] op;

        tbl[0]  = '{OP_PUSH, 0, 0, K_RETIRE, 4, 1, 1, 0, 0};
        tbl[1]  = '{OP_PUSH, 1, 2, K_RETIRE, 7, 2, 1, 0, 0};
        tbl[2]  = '{OP_ADD,  0, 0, K_RETIRE, 5, 1, 1, 2, 0};
        tbl[3]  = '{OP_PUSH, 0, 1, K_RETIRE, 5, 2, 1, 0, 0};
        tbl[4]  = '{OP_SUB,  2, 0, K_RETIRE, 7, 1, 1, 2, 0};
        tbl[5]  = '{OP_DUP,  0, 0, K_RETIRE, 4, 2, 1, 0, 0};
        tbl[6]  = '{OP_XOR,  0, 0, K_RETIRE, 5, 1, 1, 2, 0};
        tbl[7]  = '{OP_NOT,  1, 0, K_RETIRE, 5, 1, 1, 1, 0};
        tbl[8]  = '{OP_JZ,   0, 0, K_RETIRE, 3, 1, 0, 0, 0};
        tbl[9]  = '{OP_JMP,  0, 0, K_RETIRE, 3, 1, 0, 0, 0};
        tbl[10] = '{OP_POP,  0, 3, K_RETIRE, 6, 0, 0, 1, 0};
        tbl[11] = '{OP_POP,  0, 0, K_TRAP,   3, 0, 0, 0, 1};

        // Power-on reset
        rst = 1'b1; mem_ready = 1'b0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset strobes mr0", w_vec, 17'h0);
        mem_ready = 1'b1;
        #1;
        chk("reset strobes mr1", w_vec, M_FI);
        chk("reset sp_count", sp_count, 0);
        chk("reset flags", {halted, trap, trap_code}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Strobe traces
        step(1, M_FI); step(1, 0); step(1, M_ADR); step(1, M_DSEL | M_PUSH | M_RET);
        run_seq(OP_PUSH, 1, "seq_push");
        step(1, M_FI); step(1, 0); step(0, M_ADR); step(1, M_ADR);
        step(0, M_DSEL | M_PUSH | M_RET);
        run_seq(OP_PUSH, 2, "seq_push_wait");
        step(1, M_FI); step(1, M_POP); step(1, M_POP | M_AW);
        step(1, M_SA | M_SB | alu(3'b001)); step(1, M_PUSH | M_RET);
        run_seq(OP_SUB, 1, "seq_sub");
        step(1, M_FI); step(1, M_TOS); step(1, M_AW);
        step(1, M_SA | alu(3'b110) | M_PUSH | M_RET);
        run_seq(OP_DUP, 2, "seq_dup");
        step(1, M_FI); step(1, M_POP); step(1, M_POP | M_AW);
        step(1, M_SA | M_SB | alu(3'b101)); step(1, M_PUSH | M_RET);
        run_seq(OP_XOR, 1, "seq_xor");
        step(1, M_FI); step(1, M_TOS); step(1, M_AW);
        step(1, M_SA | alu(3'b110) | M_PUSH | M_RET);
        run_seq(OP_DUP, 2, "seq_dup2");
        step(1, M_FI); step(1, M_POP); step(1, M_POP | M_AW);
        step(1, M_SA | M_SB | alu(3'b010)); step(1, M_PUSH | M_RET);
        run_seq(OP_AND, 1, "seq_and");
        step(1, M_FI); step(1, M_TOS); step(1, M_AW);
        step(1, M_SA | alu(3'b110) | M_PUSH | M_RET);
        run_seq(OP_DUP, 2, "seq_dup3");
        step(1, M_FI); step(1, M_POP); step(1, M_POP | M_AW);
        step(1, M_SA | M_SB | alu(3'b100)); step(1, M_PUSH | M_RET);
        run_seq(OP_OR, 1, "seq_or");
        step(1, M_FI); step(1, M_TOS); step(1, M_AW);
        step(1, M_SA | alu(3'b110) | M_PUSH | M_RET);
        run_seq(OP_DUP, 2, "seq_dup4");
        step(1, M_FI); step(1, M_POP); step(1, M_POP | M_AW);
        step(1, M_SA | M_SB | alu(3'b000)); step(1, M_PUSH | M_RET);
        run_seq(OP_ADD, 1, "seq_add");
        step(1, M_FI); step(1, M_TOS); step(1, M_PCS | M_PCJZ | M_RET);
        run_seq(OP_JZ, 1, "seq_jz");
        step(1, M_FI); step(1, M_POP); step(1, M_SB | alu(3'b011));
        step(1, M_PUSH | M_RET);
        run_seq(OP_NOT, 1, "seq_not");
        step(0, 0); step(1, M_FI); step(1, 0); step(1, M_PCS | M_PCW | M_RET);
        run_seq(OP_JMP, 1, "seq_jmp_fetchwait");
        step(1, M_FI); step(0, M_POP); step(0, M_ADR | M_MW); step(0, M_ADR | M_MW);
        step(0, M_ADR | M_MW); step(1, M_ADR | M_MW | M_RET);
        run_seq(OP_POP, 0, "seq_pop_wait3");
        step(1, M_FI); step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(1, 0);
        run_seq(OP_HALT, 0, "seq_halt");
        chk("halt halted", halted, 1);
        chk("halt trap", trap, 0);
        do_reset("after_halt");

        // Instruction-level vector table
        for (int i = 0; i < 12; i++)
            run_instr(tbl[i].op, tbl[i].nf, tbl[i].nm, tbl[i].kind, tbl[i].len,
                      tbl[i].sp, tbl[i].npush, tbl[i].npop, tbl[i].code,
                      $sformatf("tbl%0d", i));
        do_reset("after_tbl");

        // Underflow: ADD with one entry, trap held for 20 cycles
        run_instr(OP_PUSH, 0, 0, K_RETIRE, 4, 1, 1, 0, 0, "uf_push");
        run_instr(OP_ADD, 0, 0, K_TRAP, 3, 1, 0, 0, 1, "uf_add");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode = 4'($urandom);
            @(negedge clk);
            if (!trap || trap_code != 2'b01 || w_vec != 17'h0 || sp_count != 1) bad++;
            @(posedge clk); #1;
        end
        chk("trap_hold_bad_cycles", bad, 0);
        do_reset("after_uf");

        // Overflow: fill the stack, then DUP and PUSH must trap
        for (int i = 0; i < DEPTH; i++)
            run_instr(OP_PUSH, 0, 0, K_RETIRE, 4, i + 1, 1, 0, 0,
                      $sformatf("fill%0d", i));
        run_instr(OP_DUP, 0, 0, K_TRAP, 3, DEPTH, 0, 0, 2, "of_dup");
        do_reset("after_of_dup");
        for (int i = 0; i < DEPTH; i++)
            run_instr(OP_PUSH, 0, 0, K_RETIRE, 4, i + 1, 1, 0, 0,
                      $sformatf("refill%0d", i));
        run_instr(OP_PUSH, 1, 0, K_TRAP, 4, DEPTH, 0, 0, 2, "of_push");
        do_reset("after_of_push");
        run_instr(4'd12, 0, 0, K_TRAP, 3, 0, 0, 0, 3, "illegal12");
        do_reset("after_illegal");

        // Reset in the middle of a stalled MEM_RD
        run_instr(OP_PUSH, 0, 0, K_RETIRE, 4, 1, 1, 0, 0, "mr_push");
        opcode = OP_PUSH; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_memrd strobes", w_vec, M_ADR);
        #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("mid_memrd rst strobes", w_vec, M_FI);
        chk("mid_memrd rst sp_count", sp_count, 0);
        chk("mid_memrd rst halted", halted, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized instruction stream against the model
        s = 0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 99) < 30) op = OP_PUSH;
            else op = 4'($urandom);
            nf = $urandom_range(0, 2);
            nm = $urandom_range(0, 3);
            model(op, s, nf, nm, kind, len, ns, np, npo, code);
            run_instr(op, nf, nm, kind, len, ns, np, npo, code,
                      $sformatf("rnd%0d", t));
            s = ns;
            if (kind != K_RETIRE) begin
                do_reset($sformatf("rnd%0d", t));
                s = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
